multi_add_acc: RTL
==================

Name: multi_add_acc

Overview:
- Parametrised sequential successor to the combinational three-operand 6-bit adder.
- Accepts up to NUM_OPS unsigned WIDTH-bit operands, one per beat, over a valid/ready stream, plus a carry-in sampled on the first beat.
- Accumulates the operands into a full-precision sum and presents the result through an output valid/ready handshake.
- Sits between the lab operand source (switches or test stimulus) and the display/check logic.

Parameters:
- WIDTH, 6, operand width in bits (>=1).
- NUM_OPS, 3, maximum operands per transaction (>=1).
- SUM_W, WIDTH+$clog2(NUM_OPS+1), result width. Derived; not overridden.
- CNT_W, $clog2(NUM_OPS+1), operand-counter width. Derived.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous abort: return to IDLE and drop any partial sum.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  operand.
- in_ci  input  1  carry-in; sampled only on the first beat of a transaction.
- in_last  input  1  marks the final operand of a transaction.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  SUM_W  ci + sum of accepted operands.
- out_cnt  output  CNT_W  number of operands in the result.
- out_len_err  output  1  NUM_OPS operands were accepted without in_last.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, accumulator=0, count=0, in_ready=1, out_valid=0, out_sum=0, out_cnt=0, out_len_err=0.
- Beat acceptance: a beat is accepted when in_valid && in_ready at a rising edge.
- FSM states:
  - IDLE: in_ready=1. On accept: acc = in_data + in_ci (zero-extended to SUM_W), count=1. If in_last or NUM_OPS==1, go to DONE; otherwise go to ACCUM.
  - ACCUM: in_ready=1. On accept: acc = acc + in_data, count = count+1. If in_last or count+1==NUM_OPS, go to DONE; otherwise stay in ACCUM. in_ci is ignored in ACCUM.
  - DONE: in_ready=0, out_valid=1. out_sum, out_cnt and out_len_err are stable until out_ready. On out_valid && out_ready, go to IDLE the next cycle. There is no same-cycle overlap with the next transaction.
- Latency: out_valid rises on the cycle after the edge that accepted the final beat.
- out_len_err: set at entry to DONE only when the NUM_OPS limit ended the transaction and in_last was 0 on that beat. If in_last=1 on the NUM_OPS-th beat, out_len_err=0. Cleared on the output handshake.
- Width rule: SUM_W guarantees no overflow. Worst case is NUM_OPS*(2^WIDTH-1)+1; no truncation or wrap is permitted.
- out_sum, out_cnt and out_len_err are registered and hold their last values outside DONE. Only out_valid qualifies them.
- clr: takes priority over every other event in any state. Next state is IDLE with acc=0, count=0, out_valid=0; any result not yet taken is discarded. A beat presented in the same cycle as clr is not accepted.
- Asynchronous reset mid-transaction: all state returns to the reset values immediately, independent of clk.
- Stalls: in_valid low in ACCUM holds state indefinitely. out_ready low in DONE holds indefinitely.

Decomposition:
- Shared package multi_add_pkg holds:
  - the state enum (IDLE, ACCUM, DONE);
  - a function computing SUM_W from WIDTH and NUM_OPS, shared with the bench's reference model.
- The datapath (accumulator register plus adder) is small enough to stay inline.
- One optional sub-module, add_acc_dp: SUM_W accumulator with load and add controls. It is natural if a wider multi-lane variant follows.

Test Plan:
- Defaults (WIDTH=6, NUM_OPS=3), beats 63, 63 (ci=1), then 63 with last=1 -> out_sum=190, out_cnt=3, out_len_err=0; out_valid on the cycle after beat 3.
- Beats 5 (ci=0), then 9 with last=1 -> out_sum=14, out_cnt=2; in_ready=0 while out_valid holds through 4 cycles of out_ready=0, out_sum stable.
- Beats 1, 2, 3, none with last -> DONE after beat 3, out_sum=6, out_cnt=3, out_len_err=1.
- Beats 10 then 20, then clr in the next cycle with in_valid=1, data 7 -> IDLE, beat 7 not accepted. A fresh transaction of 4 with last=1 -> out_sum=4, out_cnt=1.
- rst_n low asynchronously while in ACCUM -> in_ready=1, out_valid=0, out_sum=0 before the next clk edge.
- Exhaustive random check at defaults: 3-operand transactions with random operands, random ci and random valid/ready stalls, compared against the integer sum a+b+c+ci. Repeat with WIDTH=8, NUM_OPS=1: operand 255 with ci=1 -> out_sum=256.

Source files
------------

// File: rtl/multi_add_pkg.sv
// Shared definitions for the sequential multi-operand adder: FSM state codes
// and the result-width rule used by the RTL and by the bench's reference model.
package multi_add_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Enough headroom for num_ops full-scale operands plus a carry-in.
    function automatic int calc_sum_w(input int width, input int num_ops);
        return width + $clog2(num_ops + 1);
    endfunction

endpackage

// File: rtl/add_acc_dp.sv
// Full-precision accumulator: load starts a new sum, add extends it,
// clr zeroes it. sum_nxt_o is the value the register takes on load/add.
module add_acc_dp
    import multi_add_pkg::*;
#(
    parameter int SUM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             add_i,
    input  logic [SUM_W-1:0] operand_i,
    output logic [SUM_W-1:0] sum_nxt_o
);

    logic [SUM_W-1:0] acc_q;

    assign sum_nxt_o = load_i ? operand_i : (acc_q + operand_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (load_i || add_i) begin
            acc_q <= sum_nxt_o;
        end
    end

endmodule

// File: rtl/multi_add_acc.sv
// Sequential multi-operand adder: one operand per accepted beat, carry-in on
// the first beat, registered full-precision result behind a valid/ready port.
module multi_add_acc
    import multi_add_pkg::*;
#(
    parameter  int WIDTH   = 6,
    parameter  int NUM_OPS = 3,
    localparam int SUM_W   = calc_sum_w(WIDTH, NUM_OPS),
    localparam int CNT_W   = $clog2(NUM_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_ci,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_len_err
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] out_sum_q;
    logic [CNT_W-1:0] out_cnt_q;
    logic             out_err_q;

    logic             accept;
    logic             final_beat;
    logic             hit_limit;
    logic [CNT_W-1:0] cnt_inc;
    logic [SUM_W-1:0] operand;
    logic [SUM_W-1:0] sum_nxt;

    assign in_ready  = (state_q != ST_DONE);
    assign out_valid = (state_q == ST_DONE);

    // A beat coinciding with clr is dropped, so clr gates acceptance.
    assign accept     = in_valid && in_ready && !clr;
    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign hit_limit  = (cnt_inc == CNT_W'(NUM_OPS));
    assign final_beat = in_last || hit_limit;

    // Carry-in only counts on the first beat of a transaction.
    assign operand = {{(SUM_W-WIDTH){1'b0}}, in_data}
                   + SUM_W'((state_q == ST_IDLE) && in_ci);

    add_acc_dp #(
        .SUM_W(SUM_W)
    ) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (clr),
        .load_i   (accept && (state_q == ST_IDLE)),
        .add_i    (accept && (state_q == ST_ACCUM)),
        .operand_i(operand),
        .sum_nxt_o(sum_nxt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        cnt_d   = cnt_inc;
                        state_d = final_beat ? ST_DONE : ST_ACCUM;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Result registers hold their last values outside DONE; only out_valid qualifies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum_q <= '0;
            out_cnt_q <= '0;
            out_err_q <= 1'b0;
        end else if (accept && final_beat) begin
            out_sum_q <= sum_nxt;
            out_cnt_q <= cnt_inc;
            out_err_q <= hit_limit && !in_last;
        end else if (!clr && out_valid && out_ready) begin
            out_err_q <= 1'b0;
        end
    end

    assign out_sum     = out_sum_q;
    assign out_cnt     = out_cnt_q;
    assign out_len_err = out_err_q;

endmodule
